// File: rtl/uart_cmd_master.sv
// UART command master: serializes host commands as UART frames and
// collects the 1- or 2-byte response returned by the far end.
module uart_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUNC_WIDTH     = 4,
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_A,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_B,
    input  logic [FUNC_WIDTH-1:0]   CMD_FUNC,
    input  logic                    PAR_EN,
    input  logic                    PAR_TYP,
    output logic                    TX_OUT,
    input  logic                    RX_IN,
    output logic                    RSP_VALID,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_ERROR,
    output logic                    RSP_TIMEOUT
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] DBIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] RF_WR   = 2'd0;
    localparam logic [1:0] RF_RD   = 2'd1;
    localparam logic [1:0] ALU_OP  = 2'd2;
    localparam logic [1:0] ALU_NOP = 2'd3;

    typedef enum logic [1:0] {M_IDLE, M_SEND, M_WAIT} mstate_t;
    typedef enum logic [1:0] {T_START, T_DATA, T_PAR, T_STOP} tstate_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rstate_t;

    mstate_t m_q, m_nxt;
    tstate_t t_q, t_nxt;
    rstate_t r_q, r_nxt;

    logic [CW-1:0] tcnt_q, tcnt_nxt;
    logic [BW-1:0] tbit_q, tbit_nxt;
    logic [1:0]    fidx_q, fidx_nxt;

    logic [1:0]            typ_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [FUNC_WIDTH-1:0] func_q;
    logic                  par_en_q, par_typ_q;

    logic [DATA_WIDTH-1:0] frm [4];
    logic [1:0]            last_frm;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  accept, bit_end;

    logic                  rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]         rcnt_q, rcnt_nxt;
    logic [BW-1:0]         rbit_q, rbit_nxt;
    logic [DATA_WIDTH-1:0] rsh_q, rsh_nxt;
    logic                  rpar_q, rpar_nxt;
    logic                  start_det, byte_done, byte_err;

    logic [TW-1:0]         to_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  got_lo_q, err_q;
    logic                  final_byte, done, to_hit;

    assign CMD_READY = (m_q == M_IDLE);
    assign accept    = CMD_READY && CMD_VALID;
    assign bit_end   = (tcnt_q == BIT_LAST);
    assign tx_byte   = frm[fidx_q];

    always_comb begin
        frm[0]   = '0;
        frm[1]   = '0;
        frm[2]   = '0;
        frm[3]   = '0;
        last_frm = 2'd0;
        unique case (typ_q)
            RF_WR: begin
                frm[0]   = DATA_WIDTH'(8'hAA);
                frm[1]   = DATA_WIDTH'(addr_q);
                frm[2]   = a_q;
                last_frm = 2'd2;
            end
            RF_RD: begin
                frm[0]   = DATA_WIDTH'(8'hBB);
                frm[1]   = DATA_WIDTH'(addr_q);
                last_frm = 2'd1;
            end
            ALU_OP: begin
                frm[0]   = DATA_WIDTH'(8'hCC);
                frm[1]   = a_q;
                frm[2]   = b_q;
                frm[3]   = DATA_WIDTH'(func_q);
                last_frm = 2'd3;
            end
            ALU_NOP: begin
                frm[0]   = DATA_WIDTH'(8'hDD);
                frm[1]   = DATA_WIDTH'(func_q);
                last_frm = 2'd1;
            end
        endcase
    end

    always_comb begin
        m_nxt    = m_q;
        t_nxt    = t_q;
        tcnt_nxt = tcnt_q;
        tbit_nxt = tbit_q;
        fidx_nxt = fidx_q;
        unique case (m_q)
            M_IDLE: begin
                if (CMD_VALID) begin
                    m_nxt    = M_SEND;
                    t_nxt    = T_START;
                    tcnt_nxt = '0;
                    tbit_nxt = '0;
                    fidx_nxt = '0;
                end
            end
            M_SEND: begin
                tcnt_nxt = bit_end ? '0 : tcnt_q + 1'b1;
                if (bit_end) begin
                    unique case (t_q)
                        T_START: begin
                            t_nxt    = T_DATA;
                            tbit_nxt = '0;
                        end
                        T_DATA: begin
                            if (tbit_q == DBIT_LAST)
                                t_nxt = par_en_q ? T_PAR : T_STOP;
                            else
                                tbit_nxt = tbit_q + 1'b1;
                        end
                        T_PAR: t_nxt = T_STOP;
                        T_STOP: begin
                            if (fidx_q == last_frm) begin
                                m_nxt = (typ_q == RF_WR) ? M_IDLE : M_WAIT;
                            end else begin
                                fidx_nxt = fidx_q + 1'b1;
                                t_nxt    = T_START;
                            end
                        end
                    endcase
                end
            end
            M_WAIT: begin
                if (done || to_hit)
                    m_nxt = M_IDLE;
            end
            default: m_nxt = M_IDLE;
        endcase
    end

    always_comb begin
        TX_OUT = 1'b1;
        if (m_q == M_SEND) begin
            unique case (t_q)
                T_START: TX_OUT = 1'b0;
                T_DATA:  TX_OUT = tx_byte[tbit_q];
                T_PAR:   TX_OUT = ^tx_byte ^ par_typ_q;
                T_STOP:  TX_OUT = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_q       <= M_IDLE;
            t_q       <= T_START;
            tcnt_q    <= '0;
            tbit_q    <= '0;
            fidx_q    <= '0;
            typ_q     <= RF_WR;
            addr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            m_q    <= m_nxt;
            t_q    <= t_nxt;
            tcnt_q <= tcnt_nxt;
            tbit_q <= tbit_nxt;
            fidx_q <= fidx_nxt;
            if (accept) begin
                typ_q     <= CMD_TYPE;
                addr_q    <= CMD_ADDR;
                a_q       <= CMD_DATA_A;
                b_q       <= CMD_DATA_B;
                func_q    <= CMD_FUNC;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    // Receiver: samples at mid-bit; a byte completes at mid-stop.
    always_comb begin
        r_nxt     = r_q;
        rcnt_nxt  = rcnt_q + 1'b1;
        rbit_nxt  = rbit_q;
        rsh_nxt   = rsh_q;
        rpar_nxt  = rpar_q;
        start_det = 1'b0;
        byte_done = 1'b0;
        byte_err  = 1'b0;
        unique case (r_q)
            R_IDLE: begin
                rcnt_nxt = '0;
                if (rx_prev && !rx_s2)
                    r_nxt = R_START;
            end
            R_START: begin
                if (rcnt_q == BIT_HALF) begin
                    rcnt_nxt = '0;
                    if (rx_s2) begin
                        r_nxt = R_IDLE;
                    end else begin
                        start_det = 1'b1;
                        r_nxt     = R_DATA;
                        rbit_nxt  = '0;
                        rpar_nxt  = 1'b0;
                    end
                end
            end
            R_DATA: begin
                if (rcnt_q == BIT_LAST) begin
                    rcnt_nxt = '0;
                    rsh_nxt  = {rx_s2, rsh_q[DATA_WIDTH-1:1]};
                    if (rbit_q == DBIT_LAST)
                        r_nxt = par_en_q ? R_PAR : R_STOP;
                    else
                        rbit_nxt = rbit_q + 1'b1;
                end
            end
            R_PAR: begin
                if (rcnt_q == BIT_LAST) begin
                    rcnt_nxt = '0;
                    rpar_nxt = rx_s2 ^ (^rsh_q) ^ par_typ_q;
                    r_nxt    = R_STOP;
                end
            end
            R_STOP: begin
                if (rcnt_q == BIT_LAST) begin
                    rcnt_nxt  = '0;
                    byte_done = 1'b1;
                    byte_err  = rpar_q | ~rx_s2;
                    r_nxt     = R_IDLE;
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            r_q     <= R_IDLE;
            rcnt_q  <= '0;
            rbit_q  <= '0;
            rsh_q   <= '0;
            rpar_q  <= 1'b0;
        end else begin
            rx_s1   <= RX_IN;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            r_q     <= r_nxt;
            rcnt_q  <= rcnt_nxt;
            rbit_q  <= rbit_nxt;
            rsh_q   <= rsh_nxt;
            rpar_q  <= rpar_nxt;
        end
    end

    assign final_byte = (typ_q == RF_RD) || got_lo_q;
    assign done       = (m_q == M_WAIT) && byte_done && final_byte;
    // Completion outranks a timeout landing in the same cycle.
    assign to_hit     = (m_q == M_WAIT) && !done && (to_q == TO_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            to_q        <= '0;
            lo_q        <= '0;
            got_lo_q    <= 1'b0;
            err_q       <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
            RSP_ERROR   <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            to_q <= (m_q != M_WAIT || start_det) ? '0 : to_q + 1'b1;
            if (accept) begin
                got_lo_q <= 1'b0;
                err_q    <= 1'b0;
            end else if (done) begin
                RSP_VALID   <= 1'b1;
                RSP_TIMEOUT <= 1'b0;
                RSP_ERROR   <= err_q | byte_err;
                RSP_DATA    <= (typ_q == RF_RD) ? {{DATA_WIDTH{1'b0}}, rsh_q}
                                                : {rsh_q, lo_q};
            end else if (to_hit) begin
                RSP_VALID   <= 1'b1;
                RSP_TIMEOUT <= 1'b1;
                RSP_ERROR   <= err_q;
                RSP_DATA    <= '0;
            end else if (m_q == M_WAIT && byte_done) begin
                lo_q     <= rsh_q;
                got_lo_q <= 1'b1;
                err_q    <= err_q | byte_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: directed and random commands against a
// frame-level model of the serial link.
module tb_uart_cmd_master;
    localparam int CPB = 16;
    localparam int TO  = 4096;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [3:0]  CMD_ADDR = 4'd0;
    logic [7:0]  CMD_DATA_A = 8'd0;
    logic [7:0]  CMD_DATA_B = 8'd0;
    logic [3:0]  CMD_FUNC = 4'd0;
    logic        PAR_EN = 1'b0;
    logic        PAR_TYP = 1'b0;
    logic        TX_OUT;
    logic        RX_IN = 1'b1;
    logic        RSP_VALID;
    logic [15:0] RSP_DATA;
    logic        RSP_ERROR;
    logic        RSP_TIMEOUT;

    uart_cmd_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUNC_WIDTH(4),
        .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
        .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B),
        .CMD_FUNC(CMD_FUNC), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT), .RX_IN(RX_IN),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .RSP_ERROR(RSP_ERROR), .RSP_TIMEOUT(RSP_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         st;
    } frm_t;

    typedef struct {
        logic [15:0] d;
        logic        e;
        logic        t;
        int          c;
        logic        rdy;
    } rsp_t;

    frm_t       tx_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] exp_q[$];
    logic       mon_par = 1'b0;
    frm_t       mon_f;
    int         last_stop_c = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial line decoder for TX_OUT, sampling each bit at its middle.
    always begin
        @(negedge CLK);
        if (!RST && TX_OUT === 1'b0) begin
            mon_f.st = cyc;
            mon_f.p  = 1'b0;
            repeat (CPB / 2) @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge CLK);
                mon_f.d[i] = TX_OUT;
            end
            if (mon_par) begin
                repeat (CPB) @(negedge CLK);
                mon_f.p = TX_OUT;
            end
            repeat (CPB) @(negedge CLK);
            mon_f.s = TX_OUT;
            repeat (CPB / 2 - 1) @(negedge CLK);
            tx_q.push_back(mon_f);
        end
    end

    always @(negedge CLK) begin
        if (RSP_VALID === 1'b1)
            rsp_q.push_back('{RSP_DATA, RSP_ERROR, RSP_TIMEOUT, cyc, CMD_READY});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic build_exp(input logic [1:0] t, input logic [3:0] ad,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] f);
        exp_q.delete();
        case (t)
            2'd0: begin
                exp_q.push_back(8'hAA);
                exp_q.push_back({4'h0, ad});
                exp_q.push_back(a);
            end
            2'd1: begin
                exp_q.push_back(8'hBB);
                exp_q.push_back({4'h0, ad});
            end
            2'd2: begin
                exp_q.push_back(8'hCC);
                exp_q.push_back(a);
                exp_q.push_back(b);
                exp_q.push_back({4'h0, f});
            end
            default: begin
                exp_q.push_back(8'hDD);
                exp_q.push_back({4'h0, f});
            end
        endcase
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic pe,
                              input logic pt, input logic bad_par,
                              input logic bad_stop);
        RX_IN = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (CPB) @(negedge CLK);
        end
        if (pe) begin
            RX_IN = 1'((($countones(d)) + int'(pt) + int'(bad_par)) % 2);
            repeat (CPB) @(negedge CLK);
        end
        last_stop_c = cyc;
        RX_IN = ~bad_stop;
        repeat (CPB) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [3:0] ad,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] f, input logic pe,
                          input logic pt, output int acc);
        int w;
        w = 0;
        while (CMD_READY !== 1'b1 && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        check("ready_before_cmd", CMD_READY, 1);
        mon_par = pe;
        tx_q.delete();
        rsp_q.delete();
        build_exp(t, ad, a, b, f);
        CMD_TYPE   = t;
        CMD_ADDR   = ad;
        CMD_DATA_A = a;
        CMD_DATA_B = b;
        CMD_FUNC   = f;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        CMD_VALID  = 1'b1;
        @(negedge CLK);
        CMD_VALID  = 1'b0;
        acc = cyc;
        check("ready_drop", CMD_READY, 0);
        CMD_TYPE   = 2'($urandom);
        CMD_ADDR   = 4'($urandom);
        CMD_DATA_A = 8'($urandom);
        CMD_DATA_B = 8'($urandom);
        CMD_FUNC   = 4'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [3:0] ad,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f, input logic pe,
                           input logic pt, input logic [7:0] r0,
                           input logic [7:0] r1, input logic bp0,
                           input logic bp1, input logic bs,
                           input logic glitch, input logic noreply);
        int acc, n, fl, tt, w;
        logic [15:0] ed;
        logic ee;
        do_cmd(t, ad, a, b, f, pe, pt, acc);
        n  = exp_q.size();
        fl = pe ? 11 : 10;
        tt = n * fl * CPB;
        while (cyc < acc + tt - 1) @(negedge CLK);
        check("busy_last_stop", CMD_READY, 0);
        @(negedge CLK);
        check("tx_nframes", tx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < tx_q.size()) begin
                check("tx_byte", tx_q[i].d, exp_q[i]);
                check("tx_stop", tx_q[i].s, 1);
                check("tx_start_cyc", tx_q[i].st, acc + i * fl * CPB);
                if (pe)
                    check("tx_par", tx_q[i].p,
                          ($countones(exp_q[i]) + int'(pt)) % 2);
            end
        end
        if (t == 2'd0) begin
            check("wr_ready", CMD_READY, 1);
            repeat (20) @(negedge CLK);
            check("wr_no_rsp", rsp_q.size(), 0);
            return;
        end
        check("wait_busy", CMD_READY, 0);
        if (glitch) begin
            RX_IN = 1'b0;
            repeat (4) @(negedge CLK);
            RX_IN = 1'b1;
            repeat (30) @(negedge CLK);
        end
        if (!noreply) begin
            drive_byte(r0, pe, pt, bp0 & pe, (t == 2'd1) ? bs : 1'b0);
            if (t != 2'd1)
                drive_byte(r1, pe, pt, bp1 & pe, bs);
        end
        w = 0;
        while (rsp_q.size() == 0 && w < TO + 400) begin
            @(negedge CLK);
            w++;
        end
        check("rsp_seen", rsp_q.size() > 0, 1);
        repeat (20) @(negedge CLK);
        check("rsp_pulses", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            if (noreply) begin
                check("to_data", rsp_q[0].d, 16'h0000);
                check("to_flag", rsp_q[0].t, 1);
                check("to_err", rsp_q[0].e, 0);
                check("to_cycle", rsp_q[0].c, acc + tt + TO);
            end else begin
                ed = (t == 2'd1) ? {8'h00, r0} : {r1, r0};
                ee = (pe & (bp0 | ((t != 2'd1) & bp1))) | bs;
                check("rsp_data", rsp_q[0].d, ed);
                check("rsp_err", rsp_q[0].e, ee);
                check("rsp_to", rsp_q[0].t, 0);
                check("rsp_latency",
                      (rsp_q[0].c >= last_stop_c + CPB / 2) &&
                      (rsp_q[0].c <= last_stop_c + CPB / 2 + 4), 1);
            end
            check("rsp_ready", rsp_q[0].rdy, 1);
        end
    endtask

    initial begin
        int acc, rc;
        logic [1:0] t;
        logic pe, two;
        repeat (3) @(negedge CLK);
        check("rst_tx", TX_OUT, 1);
        check("rst_ready", CMD_READY, 1);
        check("rst_valid", RSP_VALID, 0);
        check("rst_data", RSP_DATA, 0);
        check("rst_err", RSP_ERROR, 0);
        check("rst_to", RSP_TIMEOUT, 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        run_cmd(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 1'b0, 1'b0,
                8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0,
                8'h7E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(2'd2, 4'd0, 8'h10, 8'h20, 4'd2, 1'b0, 1'b0,
                8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cmd(2'd1, 4'd9, 8'h00, 8'h00, 4'd0, 1'b0, 1'b0,
                8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'd7, 1'b1, 1'b1,
                8'h5A, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        do_cmd(2'd2, 4'd0, 8'hA5, 8'h5A, 4'd1, 1'b0, 1'b0, acc);
        while (cyc < acc + 10 * CPB + 60) @(negedge CLK);
        rc = rsp_q.size();
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_tx", TX_OUT, 1);
        check("midrst_ready", CMD_READY, 1);
        repeat (5) @(negedge CLK);
        check("midrst_tx_hold", TX_OUT, 1);
        check("midrst_valid", RSP_VALID, 0);
        RST = 1'b0;
        repeat (250) @(negedge CLK);
        check("midrst_no_rsp", rsp_q.size(), rc);
        run_cmd(2'd0, 4'($urandom), 8'($urandom), 8'h00, 4'd0, 1'b1,
                1'($urandom), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            t   = 2'($urandom);
            pe  = 1'($urandom);
            two = (t != 2'd1);
            run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom),
                    4'($urandom), pe, 1'($urandom),
                    8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) == 0),
                    two & 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);
            repeat (10) @(negedge CLK);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
